// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result bundle for nibble_serial_adder
//
// Purpose: groups the start/operand handshake and the result outputs of the
//   nibble-serial adder so source, sink and adder share one connection.
// Parameters:
//   NIBBLES   nibbles per operand; sum_out is 4*NIBBLES bits wide
// Signals (direction as seen from the adder, modport slave):
//   start     in   begin an operation (honoured in IDLE/DONE only)
//   cin_init  in   carry-in for nibble 0, captured with an accepted start
//   in_valid  in   a_nib/b_nib valid
//   in_ready  out  adder accepts a nibble this cycle
//   a_nib     in   operand A nibble, LSB nibble first
//   b_nib     in   operand B nibble, LSB nibble first
//   sum_out   out  assembled sum, nibble k in bits [4k+3:4k]
//   cout      out  carry-out of the last nibble
//   busy      out  operation in progress (ADD state)
//   done      out  one-cycle pulse when sum_out/cout are final
//   ovf       out  signed overflow flag, only with OVERFLOW_FLAG_EN defined
// The master modport is the mirror image for the operand source / result sink.

interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  logic                   start;
  logic                   cin_init;
  logic                   in_valid;
  logic                   in_ready;
  logic [3:0]             a_nib;
  logic [3:0]             b_nib;
  logic [4*NIBBLES-1:0]   sum_out;
  logic                   cout;
  logic                   busy;
  logic                   done;
`ifdef OVERFLOW_FLAG_EN
  logic                   ovf;
`endif

  modport slave (
    input  start,
    input  cin_init,
    input  in_valid,
    input  a_nib,
    input  b_nib,
    output in_ready,
    output sum_out,
    output cout,
    output busy,
`ifdef OVERFLOW_FLAG_EN
    output ovf,
`endif
    output done
  );

  modport master (
    output start,
    output cin_init,
    output in_valid,
    output a_nib,
    output b_nib,
    input  in_ready,
    input  sum_out,
    input  cout,
    input  busy,
`ifdef OVERFLOW_FLAG_EN
    input  ovf,
`endif
    input  done
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-precision adder fed one nibble per handshake
//
// Purpose: adds two 4*NIBBLES-bit unsigned operands presented LSB nibble
//   first, one nibble pair per in_valid/in_ready transfer. A combinational
//   4-bit add stage is reused every transfer; its carry-out is registered and
//   fed back as the carry-in of the next nibble.
// Parameters:
//   NIBBLES   nibbles per operand, 2..16
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high
//   bus       slave modport of nibble_serial_adder_if (start, cin_init,
//             in_valid/in_ready, a_nib, b_nib, sum_out, cout, busy, done[, ovf])
// Optional feature:
//   OVERFLOW_FLAG_EN  when defined, bus.ovf reports signed two's-complement
//                     overflow of the full-width add, registered with cout.

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_in_ready;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_accept;   // start honoured this cycle
  logic                 w_xfer;     // nibble transfer this cycle
  logic                 w_last;     // current transfer is the final nibble

  logic                 r_carry;
  logic [CW-1:0]        r_count;
  logic [4*NIBBLES-1:0] r_sum;
  logic                 r_cout;
  logic [4:0]           w_add;

  // 4-bit ripple stage: {carry, sum} of the current nibble pair
  assign w_add  = {1'b0, bus.a_nib} + {1'b0, bus.b_nib} + {4'b0000, r_carry};
  assign w_last = (r_count == CW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // handshake outputs depend on state only
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_accept   = 1'b0;
    w_xfer     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_ADD;
        end
      end
      S_ADD: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        w_xfer     = bus.in_valid;
        if (bus.in_valid && w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_ADD;
        end else begin
          w_next   = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef OVERFLOW_FLAG_EN
  logic       r_ovf;
  logic [3:0] w_low3;

  // bit 3 of w_low3 is the carry into bit 3 of the current nibble; on the
  // MSB nibble, XOR with the carry out of bit 3 gives signed overflow
  assign w_low3 = {1'b0, bus.a_nib[2:0]} + {1'b0, bus.b_nib[2:0]} + {3'b000, r_carry};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_ovf <= 1'b0;
    end else if (w_xfer && w_last) begin
      r_ovf <= w_low3[3] ^ w_add[4];
    end
  end

  assign bus.ovf = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry <= 1'b0;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_carry <= bus.cin_init;
      r_count <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_xfer) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (r_count == CW'(k)) begin
          r_sum[4*k +: 4] <= w_add[3:0];
        end
      end
      r_carry <= w_add[4];
      r_count <= r_count + CW'(1);
      if (w_last) begin
        r_cout <= w_add[4];
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.sum_out  = r_sum;
  assign bus.cout     = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
//
// Purpose: drives hand-computed operand pairs through the adder with
//   NIBBLES=4 and checks sum, carry, handshake and done timing.
// Ports: none (top-level bench). With OVERFLOW_FLAG_EN defined the ovf
//   output is checked as well.

module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst;

  int total = 0;
  int bad   = 0;

  // per-operation observations gathered by run_op
  int          n_cyc;
  int          first_done;
  int          done_cnt;
  int          rdy_lo;
  logic [15:0] res_sum;
  logic        res_cout;
`ifdef OVERFLOW_FLAG_EN
  logic        res_ovf;
`endif

  nibble_serial_adder_if #(.NIBBLES(4)) bus ();

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    n_cyc++;
    if (bus.done) begin
      done_cnt++;
      if (first_done < 0) first_done = n_cyc;
    end
  endtask

  // Called at a negedge. Starts an op, feeds 4 nibbles (optionally stalling
  // stall_len cycles before nibble stall_at), returns at the negedge where
  // done is first seen (or after a bounded wait).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input int stall_at, input int stall_len, input logic hold_start);
    n_cyc = 0; first_done = -1; done_cnt = 0; rdy_lo = 0;
    bus.start = 1'b1;
    bus.cin_init = cin;
    tick();
    bus.start = hold_start;
    for (int k = 0; k < 4; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.in_valid = 1'b0;
          bus.a_nib = 4'hF;
          bus.b_nib = 4'hF;
          if (!bus.in_ready) rdy_lo++;
          tick();
        end
      end
      bus.in_valid = 1'b1;
      bus.a_nib = a[4*k +: 4];
      bus.b_nib = b[4*k +: 4];
      if (!bus.in_ready) rdy_lo++;
      tick();
    end
    bus.in_valid = 1'b0;
    for (int w = 0; w < 10 && first_done < 0; w++) tick();
    res_sum  = bus.sum_out;
    res_cout = bus.cout;
`ifdef OVERFLOW_FLAG_EN
    res_ovf  = bus.ovf;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.sum_out !== 16'h0000) begin bad++; $display("FAIL reset_sum: got %h expected 0000", bus.sum_out); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_op(16'h00FF, 16'h0001, 1'b0, -1, 0, 1'b0);
    total++; if (first_done !== 5) begin bad++; $display("FAIL basic_latency: got %0d expected 5", first_done); end
    total++; if (res_sum !== 16'h0100) begin bad++; $display("FAIL basic_sum: got %h expected 0100", res_sum); end
    total++; if (res_cout !== 1'b0) begin bad++; $display("FAIL basic_cout: got %b expected 0", res_cout); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_done_width: got %b expected 0", bus.done); end
    total++; if (bus.sum_out !== 16'h0100) begin bad++; $display("FAIL basic_sum_hold: got %h expected 0100", bus.sum_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_ripple();
    run_op(16'hFFFF, 16'h0000, 1'b1, -1, 0, 1'b0);
    total++; if (res_sum !== 16'h0000) begin bad++; $display("FAIL ripple_sum: got %h expected 0000", res_sum); end
    total++; if (res_cout !== 1'b1) begin bad++; $display("FAIL ripple_cout: got %b expected 1", res_cout); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    run_op(16'h1234, 16'h4321, 1'b0, 2, 3, 1'b0);
    total++; if (first_done !== 8) begin bad++; $display("FAIL stall_latency: got %0d expected 8", first_done); end
    total++; if (res_sum !== 16'h5555) begin bad++; $display("FAIL stall_sum: got %h expected 5555", res_sum); end
    total++; if (res_cout !== 1'b0) begin bad++; $display("FAIL stall_cout: got %b expected 0", res_cout); end
    total++; if (rdy_lo !== 0) begin bad++; $display("FAIL stall_in_ready: got %0d low cycles expected 0", rdy_lo); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt); end
    @(negedge clk);
  endtask

  // sum_out holds 0x5555 here; rst must win over start and clear it
  task automatic test_rst_start();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.cin_init = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_start_busy: got %b expected 0", bus.busy); end
    total++; if (bus.sum_out !== 16'h0000) begin bad++; $display("FAIL rst_start_sum: got %h expected 0000", bus.sum_out); end
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_start_idle: got %b expected 0", bus.in_ready); end
  endtask

  task automatic test_abort();
    bus.start = 1'b1;
    bus.cin_init = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.a_nib = 4'hF; bus.b_nib = 4'h1;
    @(negedge clk);
    bus.a_nib = 4'hF; bus.b_nib = 4'h0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.sum_out !== 16'h0000) begin bad++; $display("FAIL abort_sum: got %h expected 0000", bus.sum_out); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL abort_in_ready: got %b expected 0", bus.in_ready); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    run_op(16'h0002, 16'h0003, 1'b0, -1, 0, 1'b0);
    total++; if (res_sum !== 16'h0005) begin bad++; $display("FAIL abort_restart_sum: got %h expected 0005", res_sum); end
    total++; if (res_cout !== 1'b0) begin bad++; $display("FAIL abort_restart_cout: got %b expected 0", res_cout); end
    @(negedge clk);
  endtask

  task automatic test_idle_valid();
    bus.in_valid = 1'b1; bus.a_nib = 4'h9; bus.b_nib = 4'h9;
    repeat (3) @(negedge clk);
    total++; if (bus.sum_out !== 16'h0005) begin bad++; $display("FAIL idle_valid_sum: got %h expected 0005", bus.sum_out); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL idle_valid_ready: got %b expected 0", bus.in_ready); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_op(16'h0011, 16'h0022, 1'b0, -1, 0, 1'b1);
    total++; if (first_done !== 5) begin bad++; $display("FAIL b2b_first_latency: got %0d expected 5", first_done); end
    total++; if (res_sum !== 16'h0033) begin bad++; $display("FAIL b2b_first_sum: got %h expected 0033", res_sum); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL b2b_first_done_count: got %0d expected 1", done_cnt); end
    run_op(16'h0100, 16'hF200, 1'b0, -1, 0, 1'b1);
    bus.start = 1'b0;
    total++; if (first_done !== 5) begin bad++; $display("FAIL b2b_second_latency: got %0d expected 5", first_done); end
    total++; if (res_sum !== 16'hF300) begin bad++; $display("FAIL b2b_second_sum: got %h expected f300", res_sum); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL b2b_second_done_count: got %0d expected 1", done_cnt); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL b2b_end_done: got %b expected 0", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_end_busy: got %b expected 0", bus.busy); end
  endtask

`ifdef OVERFLOW_FLAG_EN
  task automatic test_ovf();
    run_op(16'h7FFF, 16'h0001, 1'b0, -1, 0, 1'b0);
    total++; if (res_sum !== 16'h8000) begin bad++; $display("FAIL ovf_pos_sum: got %h expected 8000", res_sum); end
    total++; if (res_cout !== 1'b0) begin bad++; $display("FAIL ovf_pos_cout: got %b expected 0", res_cout); end
    total++; if (res_ovf !== 1'b1) begin bad++; $display("FAIL ovf_pos_flag: got %b expected 1", res_ovf); end
    @(negedge clk);
    run_op(16'hFFFF, 16'h0001, 1'b0, -1, 0, 1'b0);
    total++; if (res_sum !== 16'h0000) begin bad++; $display("FAIL ovf_neg_sum: got %h expected 0000", res_sum); end
    total++; if (res_cout !== 1'b1) begin bad++; $display("FAIL ovf_neg_cout: got %b expected 1", res_cout); end
    total++; if (res_ovf !== 1'b0) begin bad++; $display("FAIL ovf_neg_flag: got %b expected 0", res_ovf); end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cin_init = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_nib = 4'h0;
    bus.b_nib = 4'h0;
    test_reset();
    test_basic();
    test_ripple();
    test_stall();
    test_rst_start();
    test_abort();
    test_idle_valid();
    test_back_to_back();
`ifdef OVERFLOW_FLAG_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
